// File: rtl/pio_edge_capture_in_if.sv
// Avalon-MM slave bus bundle for the edge-capture input PIO.
// The master drives the register access, the slave returns data and irq.
interface pio_edge_capture_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/pio_edge_capture_in.sv
// Input PIO: synchronised pins, sticky edge capture, maskable level irq.
// Define PIO_IN_DEBOUNCE_EN to build a per-pin debounce filter.
module pio_edge_capture_in #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_edge_capture_in_if.slave bus,
    input  logic [WIDTH-1:0] in_port
);
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] clr;
    logic [1:0]       arm_cnt;
    logic [31:0]      readdata_q;
    logic             wr;
    logic             armed;
    logic             unused_ok;

    assign wr    = bus.chipselect && !bus.write_n;
    assign armed = (arm_cnt == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1      <= '0;
            s2      <= '0;
            prev    <= '0;
            arm_cnt <= 2'd0;
        end else begin
            s1   <= in_port;
            s2   <= s1;
            prev <= f;
            if (!armed)
                arm_cnt <= arm_cnt + 2'd1;
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] db_cnt [WIDTH];

    // f follows s2 only after it has disagreed for DEBOUNCE_CYCLES+1 cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f <= '0;
            for (int n = 0; n < WIDTH; n++)
                db_cnt[n] <= '0;
        end else begin
            for (int n = 0; n < WIDTH; n++) begin
                if (s2[n] == f[n]) begin
                    db_cnt[n] <= '0;
                end else if (db_cnt[n] == CW'(DEBOUNCE_CYCLES)) begin
                    f[n]      <= s2[n];
                    db_cnt[n] <= '0;
                end else begin
                    db_cnt[n] <= db_cnt[n] + CW'(1);
                end
            end
        end
    end
`else
    assign f = s2;
`endif

    always_comb begin
        det = '0;
        unique case (1'b1)
            (EDGE_TYPE == 0): det = f & ~prev;
            (EDGE_TYPE == 1): det = ~f & prev;
            default:          det = f ^ prev;
        endcase
        if (!armed)
            det = '0;
    end

    always_comb begin
        clr = '0;
        if (wr && bus.address == 2'd3)
            clr = bus.writedata[WIDTH-1:0];
    end

    // a new edge in the same cycle as a clear keeps the bit set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
            irqmask <= '0;
        end else begin
            edgecap <= (edgecap & ~clr) | det;
            if (wr && bus.address == 2'd2)
                irqmask <= bus.writedata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else begin
            unique case (bus.address)
                2'd0: readdata_q <= 32'(f);
                2'd1: readdata_q <= '0;
                2'd2: readdata_q <= 32'(irqmask);
                2'd3: readdata_q <= 32'(edgecap);
            endcase
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = |(edgecap & irqmask);

    assign unused_ok = ^{bus.writedata, DEBOUNCE_CYCLES[0]};
endmodule

// File: tb/tb_pio_edge_capture_in.sv
// Bench for pio_edge_capture_in: three DUTs (rising/falling/any) share stimulus.
// Default build is checked against a pin-history model; debounce build is directed.
module tb_pio_edge_capture_in;
    localparam int W = 4;
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int DB = 8;
`else
    localparam int DB = 50000;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [W-1:0] in_port = '0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    pio_edge_capture_in_if bus0 ();
    pio_edge_capture_in_if bus1 ();
    pio_edge_capture_in_if bus2 ();

    assign bus0.address = address;
    assign bus0.chipselect = chipselect;
    assign bus0.write_n = write_n;
    assign bus0.writedata = writedata;
    assign bus1.address = address;
    assign bus1.chipselect = chipselect;
    assign bus1.write_n = write_n;
    assign bus1.writedata = writedata;
    assign bus2.address = address;
    assign bus2.chipselect = chipselect;
    assign bus2.write_n = write_n;
    assign bus2.writedata = writedata;

    pio_edge_capture_in #(.WIDTH(W), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DB)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .in_port(in_port));
    pio_edge_capture_in #(.WIDTH(W), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(DB)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .in_port(in_port));
    pio_edge_capture_in #(.WIDTH(W), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DB)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .in_port(in_port));

    // Reference: pins[e] is the pin value sampled at the e-th edge after reset.
    logic [W-1:0] pins [0:4095];
    int           e;
    logic [W-1:0] cap [3];
    logic [W-1:0] mask;
    logic [31:0]  rd [3];

    function automatic logic [W-1:0] pin_at(int i);
        return (i < 1) ? '0 : pins[i];
    endfunction

    function automatic logic [W-1:0] detect(int t, logic [W-1:0] fv,
                                            logic [W-1:0] pv);
        if (t == 0) return fv & ~pv;
        if (t == 1) return ~fv & pv;
        return fv ^ pv;
    endfunction

    task automatic model_reset();
        e = 0;
        mask = '0;
        for (int d = 0; d < 3; d++) begin
            cap[d] = '0;
            rd[d] = '0;
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] fv;
        logic [W-1:0] pv;
        logic [W-1:0] cl;
        logic         wr;
        if (reset_n && e < 4000) begin
            e++;
            pins[e] = in_port;
            fv = pin_at(e - 2);
            pv = pin_at(e - 3);
            wr = chipselect && !write_n;
            cl = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
            for (int d = 0; d < 3; d++) begin
                case (address)
                    2'd0: rd[d] = 32'(fv);
                    2'd1: rd[d] = '0;
                    2'd2: rd[d] = 32'(mask);
                    default: rd[d] = 32'(cap[d]);
                endcase
                cap[d] = (cap[d] & ~cl) | ((e >= 4) ? detect(d, fv, pv) : '0);
            end
            if (wr && address == 2'd2)
                mask = writedata[W-1:0];
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
`ifndef PIO_IN_DEBOUNCE_EN
        check("m_rd0", bus0.readdata, rd[0]);
        check("m_rd1", bus1.readdata, rd[1]);
        check("m_rd2", bus2.readdata, rd[2]);
        check("m_irq0", 32'(bus0.irq), 32'(|(cap[0] & mask)));
        check("m_irq1", 32'(bus1.irq), 32'(|(cap[1] & mask)));
        check("m_irq2", 32'(bus2.irq), 32'(|(cap[2] & mask)));
`endif
    endtask

    task automatic bus_write(logic [1:0] a, logic [31:0] d);
        address = a;
        chipselect = 1'b1;
        write_n = 1'b0;
        writedata = d;
        tick();
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = '0;
    endtask

    initial begin
        model_reset();
`ifdef PIO_IN_DEBOUNCE_EN
        in_port = 4'h0;
`else
        in_port = 4'hF;
`endif
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_rd", bus0.readdata, 32'h0);
        check("rst_irq", 32'(bus2.irq), 32'h0);
        reset_n = 1'b1;
        address = 2'd0;

`ifndef PIO_IN_DEBOUNCE_EN
        repeat (3) tick();
        check("arm_data", bus0.readdata, 32'hF);
        address = 2'd3;
        repeat (4) tick();
        check("arm_cap0", bus0.readdata, 32'h0);
        check("arm_cap2", bus2.readdata, 32'h0);

        in_port = 4'h0;
        repeat (4) tick();
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'h1);
        in_port = 4'h1;
        tick();
        tick();
        check("e0_early", 32'(bus0.irq), 32'h0);
        tick();
        check("e0_irq", 32'(bus0.irq), 32'h1);
        address = 2'd3;
        tick();
        check("e0_cap", bus0.readdata, 32'h1);
        bus_write(2'd3, 32'h1);
        check("e0_clr", 32'(bus0.irq), 32'h0);

        bus_write(2'd2, 32'h0);
        bus_write(2'd3, 32'hF);
        in_port = 4'h5;
        tick();
        in_port = 4'h1;
        repeat (4) tick();
        address = 2'd3;
        tick();
        check("e2_cap", bus2.readdata, 32'h4);
        check("e2_irq_off", 32'(bus2.irq), 32'h0);
        bus_write(2'd2, 32'h4);
        check("e2_irq_on", 32'(bus2.irq), 32'h1);

        bus_write(2'd3, 32'hF);
        in_port = 4'h3;
        tick();
        tick();
        bus_write(2'd3, 32'h2);
        address = 2'd3;
        tick();
        check("setwins", bus0.readdata, 32'h2);

        for (int i = 0; i < 400; i++) begin
            in_port = W'($urandom);
            address = 2'($urandom);
            chipselect = 1'($urandom);
            write_n = ($urandom_range(0, 3) != 0);
            writedata = $urandom;
            tick();
        end
        chipselect = 1'b0;
        write_n = 1'b1;
`else
        repeat (20) tick();
        address = 2'd0;
        in_port = 4'h1;
        repeat (5) tick();
        in_port = 4'h0;
        repeat (20) tick();
        check("db_glitch_data", bus0.readdata, 32'h0);
        address = 2'd3;
        tick();
        check("db_glitch_cap", bus2.readdata, 32'h0);
        address = 2'd0;
        in_port = 4'h1;
        repeat (11) tick();
        check("db_hold_pre", bus0.readdata, 32'h0);
        tick();
        check("db_hold_post", bus0.readdata, 32'h1);
        repeat (9) tick();
        address = 2'd3;
        tick();
        check("db_cap", bus0.readdata, 32'h1);
`endif

        in_port = 4'h0;
        repeat (20) tick();
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'h3);
        in_port = 4'h3;
        repeat (20) tick();
        address = 2'd3;
        tick();
        check("rm_cap", bus0.readdata, 32'h3);
        check("rm_irq_pre", 32'(bus0.irq), 32'h1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rm_irq0", 32'(bus0.irq), 32'h0);
        check("rm_irq2", 32'(bus2.irq), 32'h0);
        check("rm_rd0", bus0.readdata, 32'h0);
        check("rm_rd2", bus2.readdata, 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        address = 2'd2;
        tick();
        check("rm_mask", bus0.readdata, 32'h0);
        address = 2'd3;
        tick();
        check("rm_cap_after", bus0.readdata, 32'h0);
        repeat (5) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pio_edge_capture_in.md
# pio_edge_capture_in

Avalon-MM slave input port: the host-readable counterpart of the LED output PIO on the same PCIe-to-Avalon bridge. It samples external pins (switches, push-buttons) through a two-flop synchroniser, latches selected edges into a sticky capture register, and raises a maskable interrupt toward the bridge. The host polls the pin value, clears captured edges and programs the interrupt mask over the same 2-bit-address register map style as the output PIOs.

## Interface
- WIDTH, 4: number of input pins, 1–32.
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge captured.
- DEBOUNCE_CYCLES, 50000: stable-cycle count for debounce; used only when debounce is compiled in.
- clk  in  1  system clock, the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external pins.
- readdata  out  32  registered read data; unused upper bits are 0.
- irq  out  1  level interrupt, active high.

## Operation
- Register map:
  - 0 DATA (RO): filtered pin value.
  - 1: reads 0, writes ignored.
  - 2 IRQMASK (RW, WIDTH bits).
  - 3 EDGECAP (RO; write 1 to clear a bit).
- A write is `chipselect && !write_n` at the rising edge of clk.
- Synchroniser: `s1 <= in_port; s2 <= s1`. Filtered value `f = s2`, or the debounced value when debounce is enabled.
- Edge detect:
  - `prev <= f` every cycle.
  - Rising = `f & ~prev`, falling = `~f & prev`, any = `f ^ prev`.
- Arming: a 2-bit counter counts from 0 to 3 after reset release. Edge detection is gated off until the count reaches 3. This stops a pin held high at reset from producing a false capture.
- EDGECAP bit n:
  - set when the selected edge is detected on bit n;
  - cleared by a write to address 3 with writedata[n] = 1;
  - if set and clear occur in the same cycle, set wins.
- `irq = |(EDGECAP & IRQMASK)`, decoded combinationally from registers. irq is not a latch of its own: it drops once the host clears the capture bits or masks them.
- Writes to bits [31:WIDTH] are discarded.

## Timing
- Reset values: s1, s2, prev, f, EDGECAP, IRQMASK, arm counter and readdata are all 0; irq is 0.
- Read latency is 1 cycle: `readdata <= mux(address)` every clk. It is valid in the cycle after address is presented, and chipselect does not gate it.
- Pin change sampled at edge k:
  - s2 updates at k+1;
  - EDGECAP bit and irq assert at k+2 without debounce;
  - DATA is readable in readdata at k+2 if address 0 is presented at k+1.
- An IRQMASK write at edge k affects irq immediately after edge k.
- An EDGECAP clear at edge k drops irq after edge k, unless a new edge sets the bit in the same cycle.
- Asserting reset_n low mid-operation clears all state immediately, and the arming sequence restarts on release.

## Configuration
- `PIO_IN_DEBOUNCE_EN` defined:
  - each bit gets a counter of width clog2(DEBOUNCE_CYCLES+1);
  - the counter resets to 0 whenever s2[n] == f[n] and increments while they differ;
  - on reaching DEBOUNCE_CYCLES, f[n] <= s2[n] and the counter returns to 0;
  - edge latency becomes 2 + DEBOUNCE_CYCLES + 1 cycles;
  - glitches shorter than DEBOUNCE_CYCLES cycles never reach DATA or EDGECAP.
- Not defined: no counters are built, `f = s2`, and DEBOUNCE_CYCLES is ignored.

## Test plan
- Reset with in_port = 4'hF held high, then release: DATA reads 0xF after 3 cycles, EDGECAP stays 0 and irq stays 0.
- EDGE_TYPE=0, IRQMASK=0x1, in_port 0→1 on bit 0: EDGECAP = 0x1 and irq = 1 two cycles later. A write of 0x1 to address 3 drops irq the next cycle.
- EDGE_TYPE=2, pulse bit 2 for 1 cycle with IRQMASK=0: EDGECAP = 0x4 (both edges, sticky) and irq stays 0. Writing IRQMASK=0x4 raises irq immediately.
- Clear EDGECAP bit 1 in the same cycle a new rising edge on bit 1 is detected: bit 1 remains 1.
- With `PIO_IN_DEBOUNCE_EN` and DEBOUNCE_CYCLES=8:
  - a 5-cycle glitch leaves DATA and EDGECAP unchanged;
  - a level held for 20 cycles updates DATA at 11 cycles after the pin change.
- Assert reset_n mid-capture with EDGECAP=0x3 and IRQMASK=0x3: irq, EDGECAP and IRQMASK go to 0 immediately and readdata goes to 0.
